elastic_pusher: RTL

Parametrised successor to the single-register item pusher. It latches WIDTH-bit items from an upstream producer into a DEPTH-entry first-in-first-out buffer and presents them to a downstream consumer. Both sides use a valid/ready handshake, so neither side loses or duplicates items under backpressure. It sits between item-producing stages in the pipeline wherever producer and consumer rates differ.

---
 rtl/elastic_pusher.sv | 68 ++++++
 1 files changed

// File: rtl/elastic_pusher.sv
// rtl/elastic_pusher.sv - DEPTH-entry valid/ready FIFO between item producer and consumer
// First-word fall-through; every output is a decode of registered state.
module elastic_pusher #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int ID    = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_item,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_item,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Pointers wrap explicitly so non-power-of-two depths never index past the end.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_item  = out_valid ? storage[rd_ptr] : '0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push) storage[wr_ptr] <= in_item;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (push) $display("(pusher %0d): I latched item %0d", ID, in_item);
      if (pop)  $display("(pusher %0d): I released item %0d", ID, out_item);
    end
  end
`endif

endmodule
